lfsr_gen: RTL and testbench

//  Parametrised LFSR pseudo-random generator: WIDTH-bit register, run-time choice of

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_period_mon.sv | 64 ++++++
 rtl/lfsr_gen.sv | 90 +++++++++
 tb/tb_lfsr_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants and next-state function
package lfsr_pkg;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    // Next LFSR state for a register of 'width' bits, held right-aligned in 32 bits.
    // Bits above 'width' are ignored on input and zero on output.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int          width,
                                              input logic        mode);
        logic [31:0] mask;
        logic [31:0] shifted;
        logic [31:0] gmask;
        logic        fb;
        logic        msb;
        mask    = (32'd1 << width) - 32'd1;
        shifted = (state << 1) & mask;
        msb     = |(state & (32'd1 << (width - 1)));
        fb      = ^(state & taps & mask);
        // Galois feedback mask drops the x^width term and adds the constant term
        gmask   = ((taps << 1) | 32'd1) & mask;
        if (mode == MODE_FIB) begin
            return shifted | {31'd0, fb};
        end
        return shifted ^ (msb ? gmask : 32'd0);
    endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// rtl/lfsr_period_mon.sv - cycle-length monitor: step count, wrap pulse, period capture
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             resync,
    input  logic             step,
    input  logic             hit,
    input  logic             at_seed,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] cnt_inc;
    // synced: the current count started with the register sitting on the seed,
    // so the next return to the seed closes a genuine full cycle. After a mode
    // change the count starts mid-cycle and that first partial window is discarded.
    logic             synced;

    assign cnt_inc = (&step_cnt) ? step_cnt : step_cnt + WIDTH'(1);

    // Count steps since the seed, publish the length when the seed comes round again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            synced       <= 1'b1;
        end else if (load) begin
            step_cnt     <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            synced       <= 1'b1;
        end else if (resync) begin
            step_cnt     <= '0;
            period_valid <= 1'b0;
            wrap         <= step & at_seed;
            synced       <= at_seed;
        end else if (step) begin
            if (hit) begin
                wrap     <= 1'b1;
                step_cnt <= '0;
                synced   <= 1'b1;
                if (synced) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                end
            end else begin
                wrap     <= 1'b0;
                step_cnt <= cnt_inc;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with seed load, zero protection, period measurement
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             select,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] status,
    output logic             serial_out,
    output logic             seed_err,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    generate
        if (WIDTH < 3 || WIDTH > 32 || TAPS[WIDTH-1] != 1'b1 || DEFAULT_SEED == '0) begin : g_param_check
            $error("lfsr_gen: need 3<=WIDTH<=32, TAPS msb set and nonzero DEFAULT_SEED");
        end
    endgenerate

    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt;
    logic             mode_q;
    logic             zero_state;
    logic             mode_chg;
    logic             do_step;
    logic             hit;
    logic             at_seed;

    assign load_val   = (seed == '0) ? DEFAULT_SEED : seed;
    assign nxt        = WIDTH'(lfsr_next(32'(status), 32'(TAPS), WIDTH, mode));
    assign zero_state = (status == '0);
    assign mode_chg   = select & (mode != mode_q);
    assign do_step    = select & enable & ~zero_state;
    assign hit        = (nxt == seed_reg);
    // Whether the register will sit on the seed after this edge (restarts the count aligned)
    assign at_seed    = zero_state ? (DEFAULT_SEED == seed_reg) :
                        (do_step ? hit : (status == seed_reg));
    assign serial_out = status[WIDTH-1];

    // Shift register, seed register, zero-seed flag and mode history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status   <= DEFAULT_SEED;
            seed_reg <= DEFAULT_SEED;
            seed_err <= 1'b0;
            mode_q   <= MODE_FIB;
        end else begin
            mode_q <= mode;
            if (!select) begin
                status   <= load_val;
                seed_reg <= load_val;
                seed_err <= (seed == '0);
            end else if (zero_state) begin
                status   <= DEFAULT_SEED;
                seed_err <= 1'b1;
            end else begin
                seed_err <= 1'b0;
                if (enable) begin
                    status <= nxt;
                end
            end
        end
    end

    lfsr_period_mon #(
        .WIDTH(WIDTH)
    ) u_period_mon (
        .clk         (clk),
        .rst_n       (reset),
        .load        (~select),
        .resync      (select & (zero_state | mode_chg)),
        .step        (do_step),
        .hit         (hit),
        .at_seed     (at_seed),
        .wrap        (wrap),
        .period      (period),
        .period_valid(period_valid)
    );

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen
module tb_lfsr_gen;

    localparam int         W    = 4;
    localparam logic [3:0] TAPS = 4'b1100;
    localparam logic [3:0] DEF  = 4'b0001;
    localparam int         PMAX = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       select;
    logic       enable;
    logic       mode;
    logic [3:0] seed;
    logic [3:0] status;
    logic       serial_out;
    logic       seed_err;
    logic       wrap;
    logic [3:0] period;
    logic       period_valid;

    always #5 clk = ~clk;

    lfsr_gen #(
        .WIDTH(W),
        .TAPS(TAPS),
        .DEFAULT_SEED(DEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .select      (select),
        .enable      (enable),
        .mode        (mode),
        .seed        (seed),
        .status      (status),
        .serial_out  (serial_out),
        .seed_err    (seed_err),
        .wrap        (wrap),
        .period      (period),
        .period_valid(period_valid)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       sel;
        logic       en;
        logic       md;
        logic [3:0] sd;
        logic [3:0] st;
        logic       err;
        logic       wr;
        logic       pv;
        logic [3:0] per;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic sel, input logic en, input logic md, input logic [3:0] sd,
                        input logic [3:0] st, input logic err, input logic wr, input logic pv,
                        input logic [3:0] per);
        vec_t v;
        v.sel = sel; v.en = en; v.md = md; v.sd = sd;
        v.st = st; v.err = err; v.wr = wr; v.pv = pv; v.per = per;
        tbl.push_back(v);
    endtask

    // Reference: multiply by x modulo P(x) = x^4 + x^3 + 1
    function automatic logic [3:0] ref_gal(input logic [3:0] s);
        int t;
        t = int'(s) * 2;
        if (t >= 16) t = t ^ ((int'(TAPS) * 2) + 1);
        return 4'(t);
    endfunction

    // Reference: shift in the parity of the tapped bits
    function automatic logic [3:0] ref_fib(input logic [3:0] s);
        int t;
        t = (int'(s) * 2) % 16 + ($countones(s & TAPS) % 2);
        return 4'(t);
    endfunction

    logic [3:0] m_st, m_sd;
    logic       m_mode, m_al, m_pv, m_wr, m_err;

    task automatic model_reset();
        m_st = DEF; m_sd = DEF; m_mode = 1'b0; m_al = 1'b1;
        m_pv = 1'b0; m_wr = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic back;
        if (!select) begin
            m_st  = (seed == 4'd0) ? DEF : seed;
            m_sd  = m_st;
            m_err = (seed == 4'd0);
            m_pv  = 1'b0;
            m_al  = 1'b1;
            m_wr  = 1'b0;
        end else begin
            m_err = 1'b0;
            m_wr  = 1'b0;
            if (enable) m_st = mode ? ref_gal(m_st) : ref_fib(m_st);
            back = enable && (m_st == m_sd);
            if (mode != m_mode) begin
                m_pv = 1'b0;
                m_al = (m_st == m_sd);
                m_wr = back;
            end else if (back) begin
                m_wr = 1'b1;
                if (m_al) m_pv = 1'b1;
                m_al = 1'b1;
            end
        end
        m_mode = mode;
    endtask

    initial begin
        logic [3:0] fseq [15];
        logic [3:0] gseq [15];
        logic       found;
        fseq = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
        gseq = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};

        // Load 1111, one full Fibonacci cycle, one extra step
        addv(0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++)
            addv(1, 1, 0, 4'h0, fseq[k], 0, k == 14, k == 14, 4'(PMAX));
        addv(1, 1, 0, 4'h0, 4'hE, 0, 0, 1, 4'(PMAX));
        // Zero seed substituted by default, then a full Galois cycle
        addv(0, 1, 1, 4'h0, DEF, 1, 0, 0, 0);
        for (int k = 0; k < 15; k++)
            addv(1, 1, 1, 4'h0, gseq[k], 0, k == 14, k == 14, 4'(PMAX));
        // One step, freeze for three cycles, then finish the cycle
        addv(1, 1, 1, 4'h0, gseq[0], 0, 0, 1, 4'(PMAX));
        for (int k = 0; k < 3; k++)
            addv(1, 0, 1, 4'h0, gseq[0], 0, 0, 1, 4'(PMAX));
        for (int k = 1; k < 15; k++)
            addv(1, 1, 1, 4'h0, gseq[k], 0, k == 14, 1, 4'(PMAX));

        reset = 1'b0; select = 1'b0; enable = 1'b0; mode = 1'b0; seed = 4'h0;
        #12;
        chk("reset status", 32'(status), 32'(DEF));
        chk("reset period_valid", 32'(period_valid), 0);
        chk("reset period", 32'(period), 0);
        chk("reset wrap", 32'(wrap), 0);
        chk("reset seed_err", 32'(seed_err), 0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            select = tbl[i].sel; enable = tbl[i].en; mode = tbl[i].md; seed = tbl[i].sd;
            @(posedge clk); #1;
            chk($sformatf("vec%0d status", i), 32'(status), 32'(tbl[i].st));
            chk($sformatf("vec%0d serial_out", i), 32'(serial_out), 32'(tbl[i].st[3]));
            chk($sformatf("vec%0d seed_err", i), 32'(seed_err), 32'(tbl[i].err));
            chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].wr));
            chk($sformatf("vec%0d period_valid", i), 32'(period_valid), 32'(tbl[i].pv));
            if (tbl[i].pv) chk($sformatf("vec%0d period", i), 32'(period), 32'(tbl[i].per));
        end

        // Asynchronous reset between edges, then the first edge follows select
        select = 1'b1; enable = 1'b1; mode = 1'b1;
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async reset status", 32'(status), 32'(DEF));
        chk("async reset period_valid", 32'(period_valid), 0);
        chk("async reset period", 32'(period), 0);
        mode = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post-reset first step", 32'(status), 4'h2);

        // Fibonacci cycle completes, then a mode flip invalidates the period
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (period_valid) found = 1'b1;
        end
        chk("fib period_valid rise", 32'(found), 1);
        chk("fib period", 32'(period), 32'(PMAX));
        mode = 1'b1;
        @(posedge clk); #1;
        chk("mode flip drops period_valid", 32'(period_valid), 0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (period_valid) found = 1'b1;
        end
        chk("gal period_valid recover", 32'(found), 1);
        chk("gal recovered period", 32'(period), 32'(PMAX));

        // Randomised run against the reference model
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                chk($sformatf("rnd%0d async reset", c), 32'(status), 32'(DEF));
                reset = 1'b1;
            end
            select = ($urandom_range(19) != 0);
            enable = ($urandom_range(4) != 0);
            if ($urandom_range(29) == 0) mode = ~mode;
            seed = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d status", c), 32'(status), 32'(m_st));
            chk($sformatf("rnd%0d seed_err", c), 32'(seed_err), 32'(m_err));
            chk($sformatf("rnd%0d wrap", c), 32'(wrap), 32'(m_wr));
            chk($sformatf("rnd%0d period_valid", c), 32'(period_valid), 32'(m_pv));
            if (m_pv) chk($sformatf("rnd%0d period", c), 32'(period), 32'(PMAX));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
